// File: rtl/apb_gpio_completer.sv
// apb_gpio_completer: APB completer with a small GPIO register file.
//
// Ports:
//   PCLK, PRESET         clock, synchronous active-high reset
//   PSEL .. PPROT        APB requester inputs (PPROT accepted and ignored)
//   PRDATA/PREADY/PSLVERR APB completer responses
//   gpio_in              asynchronous pin inputs (2-flop synchronized)
//   gpio_out, gpio_oe    pin drive value and per-pin output enable
//   irq                  registered level interrupt
//
// Register map (offset from BASE_ADDR):
//   0x00 DATA_OUT (RW), 0x04 DIR (RW), 0x08 DATA_IN (RO),
//   0x0C IRQ_MASK (RW), 0x10 IRQ_STATUS (W1C)  -- last two only with GPIO_IRQ_EN
//
// Build option: define GPIO_IRQ_EN to add rising-edge interrupt logic.
// Without it, 0x0C/0x10 behave as unmapped and irq is tied low.
//
// Phase FSM:
//   state     | meaning
//   ST_IDLE   | no transfer, or the cycle after a completed access
//   ST_SETUP  | setup phase seen (PSEL & !PENABLE)
//   ST_ACCESS | access phase in progress, waiting out WAIT_STATES
module apb_gpio_completer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int GPIO_WIDTH   = 32,
    parameter int WAIT_STATES  = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [STROBE_WIDTH-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [GPIO_WIDTH-1:0]   gpio_in,
    output logic [GPIO_WIDTH-1:0]   gpio_out,
    output logic [GPIO_WIDTH-1:0]   gpio_oe,
    output logic                    irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t                  state_q, state_d, phase;
    logic [3:0]              cnt_q, cnt_d;
    logic [GPIO_WIDTH-1:0]   data_out_q, data_out_d;
    logic [GPIO_WIDTH-1:0]   dir_q, dir_d;
    logic [GPIO_WIDTH-1:0]   s1_q, s2_q;

    logic                    ready;
    logic                    err;
    logic                    commit;
    logic                    mapped;
    logic                    read_only;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [DATA_WIDTH-1:0]   merge_out;
    logic [DATA_WIDTH-1:0]   merge_dir;

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0]   s3_q;
    logic [GPIO_WIDTH-1:0]   mask_q, mask_d;
    logic [GPIO_WIDTH-1:0]   status_q, status_d;
    logic [DATA_WIDTH-1:0]   merge_mask;
    logic [DATA_WIDTH-1:0]   w1c_bits;
    logic                    irq_q, irq_d;
`endif

    logic unused_ok;
    assign unused_ok = ^PPROT;

    // State register and datapath flops
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            dir_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
`ifdef GPIO_IRQ_EN
            s3_q       <= '0;
            mask_q     <= '0;
            status_q   <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            s1_q       <= gpio_in;
            s2_q       <= s1_q;
`ifdef GPIO_IRQ_EN
            s3_q       <= s2_q;
            mask_q     <= mask_d;
            status_q   <= status_d;
            irq_q      <= irq_d;
`endif
        end
    end

    // Next-state: the current bus phase is decoded from the pins, but an
    // access only counts if it follows a setup (or continues an unfinished
    // access). After the PREADY cycle the FSM falls back to IDLE, so a
    // requester holding PENABLE high cannot start a second access.
    always_comb begin
        phase = ST_IDLE;
        if (!PRESET && PSEL) begin
            if (!PENABLE)
                phase = ST_SETUP;
            else if (state_q == ST_SETUP || state_q == ST_ACCESS)
                phase = ST_ACCESS;
        end
        ready   = (phase == ST_ACCESS) && (cnt_q == 4'(WAIT_STATES));
        state_d = ready ? ST_IDLE : phase;
        cnt_d   = (phase == ST_ACCESS && !ready) ? cnt_q + 4'd1 : 4'd0;
    end

    // Address decode and read mux
    always_comb begin
        offset    = PADDR - BASE_ADDR;
        mapped    = 1'b0;
        read_only = 1'b0;
        rdata     = '0;
        case (offset)
            ADDR_WIDTH'('h00): begin mapped = 1'b1; rdata = DATA_WIDTH'(data_out_q); end
            ADDR_WIDTH'('h04): begin mapped = 1'b1; rdata = DATA_WIDTH'(dir_q); end
            ADDR_WIDTH'('h08): begin mapped = 1'b1; read_only = 1'b1; rdata = DATA_WIDTH'(s2_q); end
`ifdef GPIO_IRQ_EN
            ADDR_WIDTH'('h0C): begin mapped = 1'b1; rdata = DATA_WIDTH'(mask_q); end
            ADDR_WIDTH'('h10): begin mapped = 1'b1; rdata = DATA_WIDTH'(status_q); end
`endif
            default: ;
        endcase
        err    = (PADDR[1:0] != 2'b00) || !mapped || (PWRITE && read_only);
        commit = ready && PWRITE && !err;
    end

    // Outputs
    always_comb begin
        PREADY  = ready;
        PSLVERR = ready && err;
        PRDATA  = (ready && !err && !PWRITE) ? rdata : '0;
    end

    // Byte-strobed register writes
    always_comb begin
        wmask = '0;
        for (int i = 0; i < STROBE_WIDTH; i++)
            wmask[i*8 +: 8] = {8{PSTRB[i]}};
        merge_out  = (DATA_WIDTH'(data_out_q) & ~wmask) | (PWDATA & wmask);
        merge_dir  = (DATA_WIDTH'(dir_q) & ~wmask) | (PWDATA & wmask);
        data_out_d = data_out_q;
        dir_d      = dir_q;
        if (commit && offset == ADDR_WIDTH'('h00)) data_out_d = merge_out[GPIO_WIDTH-1:0];
        if (commit && offset == ADDR_WIDTH'('h04)) dir_d      = merge_dir[GPIO_WIDTH-1:0];
    end

`ifdef GPIO_IRQ_EN
    // A new rising edge wins over a W1C of the same bit in the same cycle.
    always_comb begin
        merge_mask = (DATA_WIDTH'(mask_q) & ~wmask) | (PWDATA & wmask);
        w1c_bits   = PWDATA & wmask;
        mask_d     = mask_q;
        status_d   = status_q;
        if (commit && offset == ADDR_WIDTH'('h0C)) mask_d = merge_mask[GPIO_WIDTH-1:0];
        if (commit && offset == ADDR_WIDTH'('h10)) status_d = status_q & ~w1c_bits[GPIO_WIDTH-1:0];
        status_d = status_d | (s2_q & ~s3_q);
        irq_d    = |(status_q & mask_q);
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_apb_gpio_completer.sv
// Directed bench for apb_gpio_completer (default parameters, WAIT_STATES=1).
module tb_apb_gpio_completer;

    localparam int WS = 1;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR;
    logic [31:0] gpio_in, gpio_out, gpio_oe;
    logic        irq;

    apb_gpio_completer #(.WAIT_STATES(WS)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] gin;
        logic [31:0] exp_rdata;
        bit          exp_err;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at 1 time unit after an edge; returns 1 time unit after the PREADY edge.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic err, output int ncyc);
        bit done;
        done = 0;
        ncyc = 0;
        rdata = '0;
        err = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #2;
            ncyc++;
            if (PREADY) begin
                rdata = PRDATA;
                err = PSLVERR;
                done = 1;
            end
            @(posedge PCLK); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: addr 0x%08h got no PREADY expected PREADY within 20 cycles", addr);
        end
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] gin,
                                input logic [31:0] exp_rdata, input bit exp_err,
                                input logic [31:0] exp_out, input logic [31:0] exp_oe);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.gin = gin;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_out = exp_out; v.exp_oe = exp_oe;
        return v;
    endfunction

    logic [31:0] rd;
    logic        er;
    int          nc;
    bit          irq_build;

    initial begin
`ifdef GPIO_IRQ_EN
        irq_build = 1;
`else
        irq_build = 0;
`endif
        //                wr    addr    wdata         strb  gin      rdata         err out           oe
        vecs.push_back(mk(1, 32'h00, 32'h0000_00A5, 4'hF, 32'h0,    32'h0,         0, 32'h0000_00A5, 32'h0));
        vecs.push_back(mk(0, 32'h00, 32'h0,         4'h0, 32'h0,    32'h0000_00A5, 0, 32'h0000_00A5, 32'h0));
        vecs.push_back(mk(1, 32'h04, 32'hFFFF_FFFF, 4'h2, 32'h0,    32'h0,         0, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(0, 32'h04, 32'h0,         4'hA, 32'h0,    32'h0000_FF00, 0, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(0, 32'h08, 32'h0,         4'h0, 32'h1234, 32'h0000_1234, 0, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(1, 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h1234, 32'h0,         1, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(0, 32'h08, 32'h0,         4'h0, 32'h1234, 32'h0000_1234, 0, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(0, 32'h02, 32'h0,         4'h0, 32'h1234, 32'h0,         1, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h1234, 32'h0,         1, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(1, 32'h02, 32'hFFFF_FFFF, 4'hF, 32'h1234, 32'h0,         1, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(1, 32'h00, 32'hDEAD_BEEF, 4'h0, 32'h1234, 32'h0,         0, 32'h0000_00A5, 32'h0000_FF00));
        vecs.push_back(mk(1, 32'h00, 32'h1122_3344, 4'h5, 32'h1234, 32'h0,         0, 32'h0022_0044, 32'h0000_FF00));
        vecs.push_back(mk(0, 32'h00, 32'h0,         4'hF, 32'h1234, 32'h0022_0044, 0, 32'h0022_0044, 32'h0000_FF00));
        vecs.push_back(mk(0, 32'h0C, 32'h0,         4'h0, 32'h1234, 32'h0,         !irq_build, 32'h0022_0044, 32'h0000_FF00));
        vecs.push_back(mk(1, 32'h10, 32'h1,         4'hF, 32'h1234, 32'h0,         !irq_build, 32'h0022_0044, 32'h0000_FF00));
        vecs.push_back(mk(1, 32'h04, 32'h0,         4'hF, 32'h1234, 32'h0,         0, 32'h0022_0044, 32'h0));
        vecs.push_back(mk(0, 32'h04, 32'h0,         4'h0, 32'h0,    32'h0,         0, 32'h0022_0044, 32'h0));

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = 3'b010; gpio_in = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_PREADY", {31'b0, PREADY}, 32'h0);
        check("reset_PSLVERR", {31'b0, PSLVERR}, 32'h0);
        check("reset_PRDATA", PRDATA, 32'h0);
        check("reset_gpio_out", gpio_out, 32'h0);
        check("reset_gpio_oe", gpio_oe, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        PRESET = 1'b0;
        idle(1);

        // Reset during the wait cycle of a write: nothing commits.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hFF; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        check("abort_wait_PREADY", {31'b0, PREADY}, 32'h0);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        check("abort_after_PREADY", {31'b0, PREADY}, 32'h0);
        check("abort_after_gpio_out", gpio_out, 32'h0);
        idle(2);
        check("abort_later_gpio_out", gpio_out, 32'h0);

        foreach (vecs[k]) begin
            gpio_in = vecs[k].gin;
            xfer(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].strb, rd, er, nc);
            check($sformatf("v%0d_err", k), {31'b0, er}, {31'b0, vecs[k].exp_err});
            check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
            check($sformatf("v%0d_cycles", k), nc, WS + 1);
            check($sformatf("v%0d_gpio_out", k), gpio_out, vecs[k].exp_out);
            check($sformatf("v%0d_gpio_oe", k), gpio_oe, vecs[k].exp_oe);
            idle(1);
        end

        // Back-to-back: write then read with no idle cycle between them.
        xfer(1, 32'h00, 32'h0000_005A, 4'hF, rd, er, nc);
        check("b2b_write_err", {31'b0, er}, 32'h0);
        check("b2b_gpio_out", gpio_out, 32'h0000_005A);
        xfer(0, 32'h00, 32'h0, 4'h0, rd, er, nc);
        check("b2b_read_rdata", rd, 32'h0000_005A);
        check("b2b_read_cycles", nc, WS + 1);
        idle(1);
        check("idle_PRDATA", PRDATA, 32'h0);

`ifdef GPIO_IRQ_EN
        gpio_in = 32'h0;
        idle(4);
        xfer(1, 32'h0C, 32'h1, 4'hF, rd, er, nc);
        check("irq_mask_err", {31'b0, er}, 32'h0);
        idle(1);
        gpio_in = 32'h1;        // rises before edge E
        @(posedge PCLK); #1;    // E
        @(posedge PCLK); #1;    // E+1
        @(posedge PCLK); #1;    // E+2: status set, irq not yet
        check("irq_e2", {31'b0, irq}, 32'h0);
        @(posedge PCLK); #1;    // E+3
        check("irq_e3", {31'b0, irq}, 32'h1);
        xfer(0, 32'h10, 32'h0, 4'h0, rd, er, nc);
        check("irq_status_read", rd, 32'h1);
        xfer(1, 32'h10, 32'h1, 4'hF, rd, er, nc);
        check("irq_w1c_err", {31'b0, er}, 32'h0);
        idle(1);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        idle(3);
        check("irq_stays_low", {31'b0, irq}, 32'h0);
`else
        gpio_in = 32'h0;
        idle(3);
        gpio_in = 32'hFFFF_FFFF;
        idle(6);
        check("irq_tied_low", {31'b0, irq}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
